// File: rtl/pio_pkg.sv
// rtl/pio_pkg.sv - register map and edge-type encodings for the input PIO
package pio_pkg;

   typedef logic [1:0] pio_addr_t;

   localparam pio_addr_t ADDR_DATA = 2'd0;
   localparam pio_addr_t ADDR_MASK = 2'd1;
   localparam pio_addr_t ADDR_RSVD = 2'd2;
   localparam pio_addr_t ADDR_ECAP = 2'd3;

   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_debounce_bit.sv
// rtl/pio_debounce_bit.sv - one input bit: synchroniser chain plus optional debounce filter
module pio_debounce_bit #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic din,
   output logic stable
);

   logic [SYNC_STAGES-1:0] sync;
   logic                   synced;

   // shift the asynchronous input through the synchroniser flops
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) sync <= '0;
      else          sync <= {sync[SYNC_STAGES-2:0], din};
   end

   assign synced = sync[SYNC_STAGES-1];

   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_bypass
         assign stable = synced;
      end else begin : g_debounce
         localparam int              CW   = $clog2(DEBOUNCE_CYCLES + 1);
         localparam logic [CW-1:0]   CMAX = CW'(DEBOUNCE_CYCLES);

         logic [CW-1:0] cnt;
         logic          stable_q;

         // count consecutive cycles the synced value disagrees with stable; accept it on the last one
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               cnt      <= '0;
               stable_q <= 1'b0;
            end else if (synced == stable_q) begin
               cnt <= '0;
            end else if (cnt == CMAX - 1'b1) begin
               stable_q <= synced;
               cnt      <= '0;
            end else if (cnt != CMAX) begin
               cnt <= cnt + 1'b1;
            end
         end

         assign stable = stable_q;
      end
   endgenerate

endmodule

// File: rtl/pio_in_edge_irq.sv
// rtl/pio_in_edge_irq.sv - Avalon-MM input PIO with per-bit edge capture and maskable irq
module pio_in_edge_irq
   import pio_pkg::*;
#(
   parameter int WIDTH           = 8,
   parameter int EDGE_TYPE       = 0,
   parameter int DEBOUNCE_CYCLES = 0,
   parameter int SYNC_STAGES     = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   logic [WIDTH-1:0] stable;
   logic [WIDTH-1:0] prev;
   logic [WIDTH-1:0] edge_det;
   logic [WIDTH-1:0] irqmask;
   logic [WIDTH-1:0] edgecapture;
   logic [WIDTH-1:0] clr;
   logic             wr_en;
   logic [31:0]      rd_next;
   logic             unused_wdata;

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         pio_debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
         ) u_bit (
            .clk     (clk),
            .reset_n (reset_n),
            .din     (in_port[i]),
            .stable  (stable[i])
         );
      end

      if (EDGE_TYPE == EDGE_RISE) begin : g_rise
         assign edge_det = stable & ~prev;
      end else if (EDGE_TYPE == EDGE_FALL) begin : g_fall
         assign edge_det = ~stable & prev;
      end else begin : g_any
         assign edge_det = stable ^ prev;
      end
   endgenerate

   assign wr_en        = chipselect & ~write_n;
   assign clr          = (wr_en && address == ADDR_ECAP) ? writedata[WIDTH-1:0] : '0;
   assign unused_wdata = ^writedata;

   // remember last cycle's debounced value for edge detection
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) prev <= '0;
      else          prev <= stable;
   end

   // interrupt mask register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                         irqmask <= '0;
      else if (wr_en && address == ADDR_MASK) irqmask <= writedata[WIDTH-1:0];
   end

   // sticky edge capture; a new edge wins over a same-cycle clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) edgecapture <= '0;
      else          edgecapture <= edge_det | (edgecapture & ~clr);
   end

   // registered level interrupt from masked captures
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) irq <= 1'b0;
      else          irq <= |(edgecapture & irqmask);
   end

   // read mux, zero-extended to the bus width
   always_comb begin
      rd_next = '0;
      case (address)
         ADDR_DATA: rd_next[WIDTH-1:0] = stable;
         ADDR_MASK: rd_next[WIDTH-1:0] = irqmask;
         ADDR_RSVD: rd_next            = '0;
         ADDR_ECAP: rd_next[WIDTH-1:0] = edgecapture;
      endcase
   end

   // readdata is registered every cycle regardless of chipselect
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) readdata <= '0;
      else          readdata <= rd_next;
   end

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// tb/tb_pio_in_edge_irq.sv - self-checking bench for pio_in_edge_irq
module tb_pio_in_edge_irq;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  address = 2'd0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = 32'h0;
   logic [7:0]  in_r = 8'h0;
   logic [7:0]  in_d = 8'h0;
   logic [31:0] rd_r, rd_a, rd_d;
   logic        irq_r, irq_a, irq_d;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model: input history indexed by clock edge since reset release
   logic [7:0] hist [0:4095];
   int         n = 0;
   logic [7:0] m_ecap_r = 8'h0;
   logic [7:0] m_ecap_a = 8'h0;
   logic [7:0] m_mask   = 8'h0;

   always #5 clk = ~clk;

   pio_in_edge_irq #(.WIDTH(8), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(0), .SYNC_STAGES(2)) u_dut_r (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_r), .readdata(rd_r), .irq(irq_r));

   pio_in_edge_irq #(.WIDTH(8), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(0), .SYNC_STAGES(2)) u_dut_a (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_r), .readdata(rd_a), .irq(irq_a));

   pio_in_edge_irq #(.WIDTH(8), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(4), .SYNC_STAGES(2)) u_dut_d (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_d), .readdata(rd_d), .irq(irq_d));

   function automatic logic [7:0] h(input int k);
      return (k < 0) ? 8'h00 : hist[k];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // one bus cycle: drive at negedge, model the edge, compare just after it
   task automatic step(input logic [1:0] a, input logic cs, input logic wn,
                       input logic [31:0] wd, input logic [7:0] ir, input logic [7:0] id);
      logic [7:0]  clr, h2, h3;
      logic [31:0] exp_rd_r, exp_rd_a;
      logic        exp_irq_r, exp_irq_a;
      @(negedge clk);
      address = a; chipselect = cs; write_n = wn; writedata = wd; in_r = ir; in_d = id;
      @(posedge clk);
      // stable after edge k equals the input sampled at edge k-1
      h2 = h(n - 2);
      h3 = h(n - 3);
      case (a)
         2'd0: begin exp_rd_r = {24'h0, h2};       exp_rd_a = {24'h0, h2};       end
         2'd1: begin exp_rd_r = {24'h0, m_mask};   exp_rd_a = {24'h0, m_mask};   end
         2'd3: begin exp_rd_r = {24'h0, m_ecap_r}; exp_rd_a = {24'h0, m_ecap_a}; end
         default: begin exp_rd_r = 32'h0; exp_rd_a = 32'h0; end
      endcase
      exp_irq_r = |(m_ecap_r & m_mask);
      exp_irq_a = |(m_ecap_a & m_mask);
      clr = (cs && !wn && a == 2'd3) ? wd[7:0] : 8'h00;
      m_ecap_r = (h2 & ~h3) | (m_ecap_r & ~clr);
      m_ecap_a = (h2 ^ h3)  | (m_ecap_a & ~clr);
      if (cs && !wn && a == 2'd1) m_mask = wd[7:0];
      hist[n] = ir;
      n++;
      #1;
      check("rd_rise", rd_r, exp_rd_r);
      check("irq_rise", {31'h0, irq_r}, {31'h0, exp_irq_r});
      check("rd_any", rd_a, exp_rd_a);
      check("irq_any", {31'h0, irq_a}, {31'h0, exp_irq_a});
   endtask

   task automatic rd_op(input logic [1:0] a, input logic [7:0] ir, input logic [7:0] id);
      step(a, 1'b1, 1'b1, 32'h0, ir, id);
   endtask

   task automatic wr_op(input logic [1:0] a, input logic [31:0] wd, input logic [7:0] ir, input logic [7:0] id);
      step(a, 1'b1, 1'b0, wd, ir, id);
   endtask

   task automatic do_reset(input logic [7:0] ir);
      @(posedge clk);
      #2;
      reset_n = 1'b0; in_r = ir; in_d = 8'h00; chipselect = 1'b0; write_n = 1'b1;
      #1;
      check("rst_rd_rise", rd_r, 32'h0);
      check("rst_irq_rise", {31'h0, irq_r}, 32'h0);
      check("rst_rd_any", rd_a, 32'h0);
      check("rst_irq_any", {31'h0, irq_a}, 32'h0);
      check("rst_rd_deb", rd_d, 32'h0);
      check("rst_irq_deb", {31'h0, irq_d}, 32'h0);
      repeat (2) @(posedge clk);
      #2;
      reset_n = 1'b1;
      n = 0; m_ecap_r = 8'h0; m_ecap_a = 8'h0; m_mask = 8'h0;
   endtask

   initial begin
      logic [7:0] cur;
      // test 1: inputs high through reset produce a rising capture after release
      do_reset(8'hFF);
      repeat (4) rd_op(2'd3, 8'hFF, 8'h00);
      check("t1_ecap_ff", rd_r, 32'h0000_00FF);
      wr_op(2'd3, 32'hFFFF_FFFF, 8'hFF, 8'h00);
      repeat (4) rd_op(2'd3, 8'h00, 8'h00);
      wr_op(2'd3, 32'h0000_00FF, 8'h00, 8'h00);
      wr_op(2'd1, 32'h0000_0001, 8'h00, 8'h00);

      // test 2: latency of data, capture and irq; write-1-to-clear
      rd_op(2'd0, 8'h05, 8'h00);
      rd_op(2'd0, 8'h05, 8'h00);
      rd_op(2'd0, 8'h05, 8'h00);
      check("t2_data_e2", rd_r, 32'h5);
      rd_op(2'd3, 8'h05, 8'h00);
      check("t2_ecap", rd_r, 32'h5);
      check("t2_irq_e3", {31'h0, irq_r}, 32'h1);
      wr_op(2'd3, 32'h1, 8'h05, 8'h00);
      rd_op(2'd3, 8'h05, 8'h00);
      check("t2_irq_clr", {31'h0, irq_r}, 32'h0);
      check("t2_ecap_clr", rd_r, 32'h4);

      // test 4: any-edge capture on bit3, re-armed after a clear between transitions
      wr_op(2'd3, 32'hFF, 8'h05, 8'h00);
      repeat (4) rd_op(2'd3, 8'h0D, 8'h00);
      check("t4_rise_bit3", {31'h0, rd_a[3]}, 32'h1);
      wr_op(2'd3, 32'h08, 8'h0D, 8'h00);
      rd_op(2'd3, 8'h0D, 8'h00);
      check("t4_cleared", {31'h0, rd_a[3]}, 32'h0);
      repeat (4) rd_op(2'd3, 8'h05, 8'h00);
      check("t4_fall_bit3", {31'h0, rd_a[3]}, 32'h1);

      // test 5: rising edge on bit2 lands on the same edge as its clear
      repeat (4) rd_op(2'd0, 8'h01, 8'h00);
      wr_op(2'd3, 32'hFF, 8'h01, 8'h00);
      rd_op(2'd0, 8'h05, 8'h00);
      rd_op(2'd0, 8'h05, 8'h00);
      wr_op(2'd3, 32'h04, 8'h05, 8'h00);
      rd_op(2'd3, 8'h05, 8'h00);
      check("t5_set_wins", {31'h0, rd_r[2]}, 32'h1);

      // test 3: debounce of 4 cycles rejects a 3-cycle pulse, accepts a 5-cycle pulse
      for (int len = 3; len <= 5; len += 2) begin
         for (int j = 0; j < 14; j++) begin
            rd_op(2'd0, 8'h05, (j < len) ? 8'h01 : 8'h00);
            check("t3_stable", rd_d, (len == 5 && j >= 6 && j <= 10) ? 32'd1 : 32'd0);
         end
         rd_op(2'd3, 8'h05, 8'h00);
         check("t3_ecap", rd_d, (len == 5) ? 32'd1 : 32'd0);
      end

      // test 6: mask gating of irq, then asynchronous reset drops it
      wr_op(2'd1, 32'h0, 8'h05, 8'h00);
      repeat (2) rd_op(2'd0, 8'h05, 8'h00);
      wr_op(2'd3, 32'hFF, 8'h05, 8'h00);
      repeat (4) rd_op(2'd3, 8'h15, 8'h00);
      check("t6_ecap", rd_r, 32'h10);
      check("t6_irq_masked", {31'h0, irq_r}, 32'h0);
      wr_op(2'd1, 32'h10, 8'h15, 8'h00);
      rd_op(2'd0, 8'h15, 8'h00);
      check("t6_irq_unmasked", {31'h0, irq_r}, 32'h1);
      do_reset(8'h00);

      // randomized traffic against the model, with a reset in the middle
      cur = 8'h00;
      for (int i = 0; i < 400; i++) begin
         if (i == 200) do_reset(8'($urandom));
         if ($urandom_range(0, 3) == 0) cur = 8'($urandom);
         step(2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), $urandom, cur, 8'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
